// File: rtl/sdram_responder.sv
// sdram_responder
//   Behavioural SDRAM device model: decodes the SDRAM command bus,
//   enforces the power-up init sequence, tracks per-bank open rows
//   and the ACTIVATE-to-column delay, stores write data and returns
//   read data after CAS latency CL through a CL-deep pipeline.
//
// Parameters
//   DATA_W  data word width
//   ROW_W   row address bits stored per bank
//   COL_W   column address bits
//   CL      CAS latency in cycles (2..3)
//   TRCD    minimum cycles from ACTIVATE to READ/WRITE (>= 1)
//
// Ports
//   CLK        sole clock, rising edge
//   RESET      synchronous, active-high reset
//   cmd        {CKE, CS_n, RAS_n, CAS_n, WE_n, BA[1:0], A10}
//   addr       row address on ACTIVATE, column address on READ/WRITE
//   dq_in      write data, sampled in the WRITE cycle
//   dq_out     read data (0 when dq_oe is low)
//   dq_oe      dq_out valid
//   init_done  initialization sequence complete
//   err        sticky protocol-violation flag
//   err_code   code of the first violation
//
// Configuration
//   SDRAM_RESP_CHECK_EN  when defined, err/err_code report violations;
//                        otherwise they are tied to 0. Illegal commands
//                        are rejected in both builds.

module sdram_responder #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4,
    parameter int CL     = 2,
    parameter int TRCD   = 2
) (
    input  logic                                         CLK,
    input  logic                                         RESET,
    input  logic [7:0]                                   cmd,
    input  logic [((ROW_W > COL_W) ? ROW_W : COL_W)-1:0] addr,
    input  logic [DATA_W-1:0]                            dq_in,
    output logic [DATA_W-1:0]                            dq_out,
    output logic                                         dq_oe,
    output logic                                         init_done,
    output logic                                         err,
    output logic [2:0]                                   err_code
);

    localparam int IDX_W = 2 + ROW_W + COL_W;
    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = (TRCD > 1) ? $clog2(TRCD) : 1;

    typedef enum logic [2:0] {
        INIT_PRE,
        INIT_REF1,
        INIT_REF2,
        INIT_MRS,
        READY
    } state_t;

    state_t                  state;
    logic [3:0]              bank_open;
    logic [ROW_W-1:0]        open_row [4];
    logic [CNT_W-1:0]        trcd_cnt [4];
    logic [DATA_W-1:0]       mem      [DEPTH];
    logic [CL-1:0]           pipe_vld;
    logic [DATA_W-1:0]       pipe_dat [CL];

    // Command decode
    logic                    cmd_sel;
    logic [2:0]              op;
    logic [1:0]              ba;
    logic                    a10;
    logic                    is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
    logic                    non_nop;
    logic [ROW_W-1:0]        row_a;
    logic [COL_W-1:0]        col_a;
    logic [IDX_W-1:0]        idx;
    logic [2:0]              viol;
    logic                    ok;
    logic                    rd_ok;
    logic                    wr_ok;

    always_comb begin
        cmd_sel = cmd[7] & ~cmd[6];
        op      = cmd[5:3];
        ba      = cmd[2:1];
        a10     = cmd[0];
        is_act  = cmd_sel && (op == 3'b011);
        is_rd   = cmd_sel && (op == 3'b101);
        is_wr   = cmd_sel && (op == 3'b100);
        is_pre  = cmd_sel && (op == 3'b010);
        is_ref  = cmd_sel && (op == 3'b001);
        is_mrs  = cmd_sel && (op == 3'b000);
        non_nop = is_act | is_rd | is_wr | is_pre | is_ref | is_mrs;
        row_a   = addr[ROW_W-1:0];
        col_a   = addr[COL_W-1:0];
        idx     = {ba, open_row[ba], col_a};
    end

    // Violation classification; any nonzero code rejects the command.
    always_comb begin
        viol = 3'd0;
        case (state)
            INIT_PRE:  if (non_nop && !(is_pre && a10)) viol = 3'd1;
            INIT_REF1,
            INIT_REF2: if (non_nop && !is_ref)          viol = 3'd1;
            INIT_MRS:  if (non_nop && !is_mrs)          viol = 3'd1;
            READY: begin
                if (is_act && bank_open[ba])
                    viol = 3'd2;
                else if ((is_rd || is_wr) && !bank_open[ba])
                    viol = 3'd3;
                else if ((is_rd || is_wr) && (trcd_cnt[ba] != '0))
                    viol = 3'd4;
                else if ((is_ref || is_mrs) && (bank_open != '0))
                    viol = 3'd5;
            end
            default:   viol = 3'd1;
        endcase
        ok    = non_nop && (viol == 3'd0) && !RESET;
        rd_ok = ok && is_rd;
        wr_ok = ok && is_wr;
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge CLK) begin
        if (wr_ok)
            mem[idx] <= dq_in;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= INIT_PRE;
            bank_open <= '0;
            init_done <= 1'b0;
            pipe_vld  <= '0;
            for (int unsigned b = 0; b < 4; b++) begin
                open_row[b] <= '0;
                trcd_cnt[b] <= '0;
            end
            for (int unsigned k = 0; k < CL; k++)
                pipe_dat[k] <= '0;
        end else begin
            for (int unsigned b = 0; b < 4; b++)
                if (trcd_cnt[b] != '0)
                    trcd_cnt[b] <= trcd_cnt[b] - 1'b1;

            case (state)
                INIT_PRE:  if (ok) state <= INIT_REF1;
                INIT_REF1: if (ok) state <= INIT_REF2;
                INIT_REF2: if (ok) state <= INIT_MRS;
                INIT_MRS: begin
                    if (ok) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY: begin
                    if (ok) begin
                        if (is_act) begin
                            bank_open[ba] <= 1'b1;
                            open_row[ba]  <= row_a;
                            trcd_cnt[ba]  <= CNT_W'(TRCD - 1);
                        end
                        if ((is_rd || is_wr) && a10)
                            bank_open[ba] <= 1'b0;
                        if (is_pre) begin
                            if (a10)
                                bank_open <= '0;
                            else
                                bank_open[ba] <= 1'b0;
                        end
                    end
                end
                default: state <= INIT_PRE;
            endcase

            // Data is captured at issue so a READ right after a WRITE
            // to the same word sees the stored value.
            pipe_vld[0] <= rd_ok;
            pipe_dat[0] <= rd_ok ? mem[idx] : '0;
            for (int unsigned k = 1; k < CL; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_dat[k] <= pipe_dat[k-1];
            end
        end
    end

    assign dq_oe  = pipe_vld[CL-1];
    assign dq_out = pipe_dat[CL-1];

`ifdef SDRAM_RESP_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err      <= 1'b0;
            err_code <= 3'd0;
        end else if (non_nop && (viol != 3'd0) && !err) begin
            err      <= 1'b1;
            err_code <= viol;
        end
    end
`else
    assign err      = 1'b0;
    assign err_code = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder
//   Directed self-checking bench for sdram_responder (default params:
//   DATA_W=16, ROW_W=4, COL_W=4, CL=2, TRCD=2). Expected error values
//   depend on whether SDRAM_RESP_CHECK_EN is defined.

module tb_sdram_responder;

    localparam logic [2:0] OP_NOP = 3'b111;
    localparam logic [2:0] OP_ACT = 3'b011;
    localparam logic [2:0] OP_RD  = 3'b101;
    localparam logic [2:0] OP_WR  = 3'b100;
    localparam logic [2:0] OP_PRE = 3'b010;
    localparam logic [2:0] OP_REF = 3'b001;
    localparam logic [2:0] OP_MRS = 3'b000;

`ifdef SDRAM_RESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        CLK;
    logic        RESET;
    logic [7:0]  cmd;
    logic [3:0]  addr;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        init_done;
    logic        err;
    logic [2:0]  err_code;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_responder #(
        .DATA_W (16),
        .ROW_W  (4),
        .COL_W  (4),
        .CL     (2),
        .TRCD   (2)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cmd       (cmd),
        .addr      (addr),
        .dq_in     (dq_in),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .init_done (init_done),
        .err       (err),
        .err_code  (err_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] mk(input logic [2:0] op, input logic [1:0] b,
                                      input logic a10);
        return {1'b1, 1'b0, op, b, a10};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one command for one cycle; returns #1 after the edge.
    task automatic issue(input logic [7:0] c, input logic [3:0] a,
                         input logic [15:0] d);
        cmd   = c;
        addr  = a;
        dq_in = d;
        @(posedge CLK);
        #1;
        cmd   = mk(OP_NOP, 2'd0, 1'b0);
    endtask

    task automatic nop();
        issue(mk(OP_NOP, 2'd0, 1'b0), 4'd0, 16'd0);
    endtask

    task automatic do_init();
        issue(mk(OP_PRE, 2'd0, 1'b1), 4'd0, 16'd0);
        nop();
        issue(mk(OP_REF, 2'd0, 1'b0), 4'd0, 16'd0);
        nop();
        issue(mk(OP_REF, 2'd0, 1'b0), 4'd0, 16'd0);
        nop();
        check("init_done_before_mrs", {31'd0, init_done}, 32'd0);
        issue(mk(OP_MRS, 2'd0, 1'b0), 4'd0, 16'd0);
        check("init_done_after_mrs", {31'd0, init_done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1;
        cmd   = mk(OP_NOP, 2'd0, 1'b0);
        addr  = '0;
        dq_in = '0;
        nop();
        nop();
        check("rst_dq_oe",     {31'd0, dq_oe},     32'd0);
        check("rst_dq_out",    {16'd0, dq_out},    32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        check("rst_err_code",  {29'd0, err_code},  32'd0);
        RESET = 1'b0;

        do_init();

        // ACT b1 r3, WRITE c5, READ c5 with auto-precharge
        issue(mk(OP_ACT, 2'd1, 1'b0), 4'd3, 16'd0);
        nop();
        issue(mk(OP_WR, 2'd1, 1'b0), 4'd5, 16'hA5A5);
        issue(mk(OP_RD, 2'd1, 1'b1), 4'd5, 16'd0);
        check("rd_lat_cl1_oe", {31'd0, dq_oe}, 32'd0);
        nop();
        check("rd_cl_oe",   {31'd0, dq_oe},  32'd1);
        check("rd_cl_data", {16'd0, dq_out}, 32'h0000A5A5);
        nop();
        check("rd_after_oe",   {31'd0, dq_oe},  32'd0);
        check("rd_after_data", {16'd0, dq_out}, 32'd0);
        // Re-ACT is only legal if auto-precharge closed bank1
        issue(mk(OP_ACT, 2'd1, 1'b0), 4'd3, 16'd0);
        check("autopre_closed_err", {31'd0, err}, 32'd0);
        nop();

        // Back-to-back reads
        issue(mk(OP_WR, 2'd1, 1'b0), 4'd0, 16'd1);
        issue(mk(OP_WR, 2'd1, 1'b0), 4'd1, 16'd2);
        issue(mk(OP_WR, 2'd1, 1'b0), 4'd2, 16'd3);
        issue(mk(OP_RD, 2'd1, 1'b0), 4'd0, 16'd0);
        check("b2b_c1_oe", {31'd0, dq_oe}, 32'd0);
        issue(mk(OP_RD, 2'd1, 1'b0), 4'd1, 16'd0);
        check("b2b_d1_oe",   {31'd0, dq_oe},  32'd1);
        check("b2b_d1_data", {16'd0, dq_out}, 32'd1);
        issue(mk(OP_RD, 2'd1, 1'b0), 4'd2, 16'd0);
        check("b2b_d2_oe",   {31'd0, dq_oe},  32'd1);
        check("b2b_d2_data", {16'd0, dq_out}, 32'd2);
        nop();
        check("b2b_d3_oe",   {31'd0, dq_oe},  32'd1);
        check("b2b_d3_data", {16'd0, dq_out}, 32'd3);
        nop();
        check("b2b_end_oe", {31'd0, dq_oe}, 32'd0);

        // Precharge bank1, then precharge already-closed bank2
        issue(mk(OP_PRE, 2'd1, 1'b0), 4'd0, 16'd0);
        issue(mk(OP_PRE, 2'd2, 1'b0), 4'd0, 16'd0);
        check("pre_closed_err", {31'd0, err}, 32'd0);

        // READ to closed bank0
        issue(mk(OP_RD, 2'd0, 1'b0), 4'd0, 16'd0);
        check("closed_err",      {31'd0, err},      {31'd0, CHK});
        check("closed_err_code", {29'd0, err_code}, CHK ? 32'd3 : 32'd0);
        check("closed_oe1", {31'd0, dq_oe}, 32'd0);
        nop();
        check("closed_oe2", {31'd0, dq_oe}, 32'd0);
        nop();
        check("closed_oe3", {31'd0, dq_oe}, 32'd0);
        issue(mk(OP_ACT, 2'd0, 1'b0), 4'd0, 16'd0);
        issue(mk(OP_ACT, 2'd0, 1'b0), 4'd0, 16'd0);
        check("sticky_err_code", {29'd0, err_code}, CHK ? 32'd3 : 32'd0);

        // Reset one cycle after a READ
        issue(mk(OP_RD, 2'd0, 1'b0), 4'd0, 16'd0);
        RESET = 1'b1;
        nop();
        RESET = 1'b0;
        check("rstmid_oe1",       {31'd0, dq_oe},     32'd0);
        check("rstmid_data",      {16'd0, dq_out},    32'd0);
        check("rstmid_init_done", {31'd0, init_done}, 32'd0);
        check("rstmid_err",       {31'd0, err},       32'd0);
        nop();
        check("rstmid_oe2", {31'd0, dq_oe}, 32'd0);
        do_init();
        issue(mk(OP_ACT, 2'd1, 1'b0), 4'd3, 16'd0);
        nop();
        issue(mk(OP_RD, 2'd1, 1'b0), 4'd5, 16'd0);
        nop();
        check("retain_oe",   {31'd0, dq_oe},  32'd1);
        check("retain_data", {16'd0, dq_out}, 32'h0000A5A5);
        nop();

        // READ before TRCD elapsed
        issue(mk(OP_ACT, 2'd2, 1'b0), 4'd1, 16'd0);
        issue(mk(OP_RD, 2'd2, 1'b0), 4'd0, 16'd0);
        check("trcd_err",      {31'd0, err},      {31'd0, CHK});
        check("trcd_err_code", {29'd0, err_code}, CHK ? 32'd4 : 32'd0);
        nop();
        check("trcd_oe", {31'd0, dq_oe}, 32'd0);
        nop();
        check("trcd_oe2", {31'd0, dq_oe}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
